ticket_arbiter: RTL and testbench

//  Shares one W-bit sequence counter among NREQ requesters in round-robin order.

---
 rtl/ticket_arbiter_pkg.sv | 31 +++
 rtl/ticket_arbiter_if.sv | 53 +++++
 rtl/ticket_arbiter_rr.sv | 53 +++++
 rtl/ticket_arbiter.sv | 93 +++++++++
 tb/tb_ticket_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ticket_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ticket_arbiter_pkg
//   Shared definitions for the ticket arbiter slice.
//   - Default parameter values (requester count, sequence width, ticket width).
//   - ticket_t: packed {epoch, seq} ticket as seen by downstream consumers.
//   - ticket_older(): age comparison that stays correct across seq roll-over.
//   No ports (package).
// -----------------------------------------------------------------------------
package ticket_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int TICKET_W = W_DEF + 1;

  typedef struct packed {
    logic             epoch;
    logic [W_DEF-1:0] seq;
  } ticket_t;

  // A is older than B. Within one epoch the smaller seq was issued first.
  // Across an epoch boundary the newer ticket has restarted from zero, so the
  // larger seq is the older one. Only valid while the in-flight tickets span
  // fewer than 2^W issues.
  function automatic logic ticket_older(input ticket_t a, input ticket_t b);
    if (a.epoch == b.epoch) begin
      return a.seq < b.seq;
    end
    return a.seq > b.seq;
  endfunction

endpackage

// File: rtl/ticket_arbiter_if.sv
// -----------------------------------------------------------------------------
// ticket_arbiter_if
//   Bundles the request/grant/ticket signals of the ticket arbiter.
//   Signals:
//     clr    requester -> arbiter  synchronous clear of count/epoch/pointer
//     hold   requester -> arbiter  blocks all grants while high
//     req    requester -> arbiter  per-requester level request (NREQ bits)
//     gnt    arbiter -> requester  one-hot grant, same cycle as req
//     ticket arbiter -> requester  {epoch, seq} for the grant holder
//     count  arbiter -> requester  next seq value to be issued
//     epoch  arbiter -> requester  current epoch bit
//     wrap   arbiter -> requester  one-cycle pulse after seq rolls over
//   Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface ticket_arbiter_if
  import ticket_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
);

  logic            clr;
  logic            hold;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [W:0]      ticket;
  logic [W-1:0]    count;
  logic            epoch;
  logic            wrap;

  modport master (
    output clr,
    output hold,
    output req,
    input  gnt,
    input  ticket,
    input  count,
    input  epoch,
    input  wrap
  );

  modport slave (
    input  clr,
    input  hold,
    input  req,
    output gnt,
    output ticket,
    output count,
    output epoch,
    output wrap
  );

endinterface

// File: rtl/ticket_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick.
//   Ports:
//     req_i  [NREQ-1:0]  request vector
//     ptr_i  [PW-1:0]    highest-priority index for this cycle
//     gnt_o  [NREQ-1:0]  one-hot grant (zero when no request)
//     idx_o  [PW-1:0]    index of the granted requester (0 when none)
//   The request vector is duplicated into a 2*NREQ-bit word and every bit
//   below ptr_i is masked off; the lowest surviving bit is the winner. Bits in
//   the upper copy stand for requesters that wrapped around past ptr_i.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] keep_mask;
  logic [2*NREQ-1:0] masked;

  assign req_dbl = {req_i, req_i};

  generate
    for (genvar gi = 0; gi < 2 * NREQ; gi++) begin : g_mask
      assign keep_mask[gi] = (gi >= int'(ptr_i));
    end
  endgenerate

  assign masked = req_dbl & keep_mask;

  // Lowest set bit of the masked double-width word.
  always_comb begin
    logic found;
    int   sel;
    found = 1'b0;
    sel   = 0;
    for (int j = 0; j < 2 * NREQ; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
    idx_o = PW'(sel % NREQ);
    gnt_o = found ? (NREQ'(1) << (sel % NREQ)) : '0;
  end

endmodule

// File: rtl/ticket_arbiter.sv
// -----------------------------------------------------------------------------
// ticket_arbiter
//   Shares one W-bit sequence counter among NREQ requesters in round-robin
//   order. Each grant hands the winner {epoch, count} as its ticket and
//   advances the count; the epoch bit flips on every roll-over so consumers
//   can keep FIFO ordering across the wrap.
//   Ports:
//     clk    clock, all state on posedge
//     rst_n  asynchronous active-low reset
//     bus    ticket_arbiter_if.slave (clr, hold, req in; gnt, ticket, count,
//            epoch, wrap out)
// -----------------------------------------------------------------------------
module ticket_arbiter
  import ticket_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  ticket_arbiter_if.slave     bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [W-1:0]    count_q, count_d;
  logic            epoch_q, epoch_d;
  logic [PW-1:0]   ptr_q,   ptr_d;
  logic            wrap_q,  wrap_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            grant_en;
  logic [NREQ-1:0] gnt;
  logic            granted;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // rst_n is included so that no ticket is shown while reset is asserted,
  // even between clock edges. clr beats everything, hold blocks issue.
  assign grant_en = rst_n & ~bus.clr & ~bus.hold;
  assign gnt      = grant_en ? arb_gnt : '0;
  assign granted  = |gnt;

  always_comb begin
    count_d = count_q;
    epoch_d = epoch_q;
    ptr_d   = ptr_q;
    wrap_d  = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      epoch_d = 1'b0;
      ptr_d   = '0;
    end else if (granted) begin
      count_d = count_q + W'(1);
      // Winner drops to lowest priority for the next pick.
      ptr_d   = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
      if (count_q == {W{1'b1}}) begin
        epoch_d = ~epoch_q;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      epoch_q <= 1'b0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      epoch_q <= epoch_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.ticket = granted ? {epoch_q, count_q} : '0;
  assign bus.count  = count_q;
  assign bus.epoch  = epoch_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_ticket_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ticket_arbiter
//   Directed scenarios for ticket_arbiter (NREQ=4, W=8). Inputs change 1ns
//   after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_ticket_arbiter;
  import ticket_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  ticket_arbiter_if #(.NREQ(4), .W(8)) bus ();

  ticket_arbiter #(.NREQ(4), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    bus.hold = 1'b0;
    bus.clr = 1'b0;
    #2;
    @(negedge clk);
    tests++;
    if (bus.gnt !== 4'b0000) begin
      fails++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 4'b0000);
    end
    tests++;
    if (bus.count !== 8'd0 || bus.epoch !== 1'b0 || bus.wrap !== 1'b0) begin
      fails++; $display("FAIL reset_state: got count=%0d epoch=%b wrap=%b expected 0/0/0",
                        bus.count, bus.epoch, bus.wrap);
    end
    next_cycle();
    $display("[TB] reset checked");
  endtask

  // Scenario 1: four requesters rotate, tickets 0..7.
  task automatic test_rotation();
    logic [3:0] exp_g;
    rst_n = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      @(negedge clk);
      tests++;
      if (bus.gnt !== exp_g || bus.ticket !== 9'(i)) begin
        fails++; $display("FAIL rotation_%0d: got gnt=%b ticket=%0h expected gnt=%b ticket=%0h",
                          i, bus.gnt, bus.ticket, exp_g, i);
      end
      $display("[TB] rotation cycle %0d gnt=%b ticket=%0h", i, bus.gnt, bus.ticket);
      next_cycle();
    end
    bus.req = 4'b0000;
    @(negedge clk);
    tests++;
    if (bus.count !== 8'd8) begin
      fails++; $display("FAIL rotation_count: got %0d expected 8", bus.count);
    end
    next_cycle();
  endtask

  // Scenario 2: sparse requests, ptr starts at 0 after clr.
  task automatic test_sparse();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001;
    bus.clr = 1'b1;
    bus.req = 4'b0101;
    @(negedge clk);
    tests++;
    if (bus.gnt !== 4'b0000) begin
      fails++; $display("FAIL sparse_clr_gnt: got %b expected 0000", bus.gnt);
    end
    next_cycle();
    bus.clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.gnt !== exp_g[i] || bus.ticket !== 9'(i)) begin
        fails++; $display("FAIL sparse_%0d: got gnt=%b ticket=%0h expected gnt=%b ticket=%0h",
                          i, bus.gnt, bus.ticket, exp_g[i], i);
      end
      $display("[TB] sparse cycle %0d gnt=%b ticket=%0h", i, bus.gnt, bus.ticket);
      next_cycle();
    end
    bus.req = 4'b0000;
    @(negedge clk);
    tests++;
    if (bus.count !== 8'd3) begin
      fails++; $display("FAIL sparse_count: got %0d expected 3", bus.count);
    end
    next_cycle();
  endtask

  // Scenario 3: single requester at full rate, through the roll-over.
  task automatic test_wrap();
    logic [8:0] exp_t [3];
    exp_t[0] = 9'h0FE; exp_t[1] = 9'h0FF; exp_t[2] = 9'h100;
    bus.clr = 1'b1;
    next_cycle();
    bus.clr = 1'b0;
    bus.req = 4'b0001;
    for (int i = 0; i < 254; i++) begin
      @(negedge clk);
      tests++;
      if (bus.gnt !== 4'b0001 || bus.ticket !== 9'(i)) begin
        fails++; $display("FAIL single_%0d: got gnt=%b ticket=%0h expected gnt=0001 ticket=%0h",
                          i, bus.gnt, bus.ticket, i);
      end
      next_cycle();
    end
    $display("[TB] single requester issued 254 tickets, count=%0d", bus.count);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.gnt !== 4'b0001 || bus.ticket !== exp_t[i]) begin
        fails++; $display("FAIL wrap_ticket_%0d: got gnt=%b ticket=%0h expected gnt=0001 ticket=%0h",
                          i, bus.gnt, bus.ticket, exp_t[i]);
      end
      tests++;
      if (bus.wrap !== (i == 2)) begin
        fails++; $display("FAIL wrap_pulse_%0d: got %b expected %b", i, bus.wrap, (i == 2));
      end
      $display("[TB] wrap cycle %0d ticket=%0h wrap=%b epoch=%b", i, bus.ticket, bus.wrap, bus.epoch);
      next_cycle();
    end
    bus.req = 4'b0000;
    @(negedge clk);
    tests++;
    if (bus.wrap !== 1'b0 || bus.epoch !== 1'b1 || bus.count !== 8'd1) begin
      fails++; $display("FAIL wrap_after: got wrap=%b epoch=%b count=%0d expected 0/1/1",
                        bus.wrap, bus.epoch, bus.count);
    end
    next_cycle();
  endtask

  // Scenario 4: hold freezes everything; resume from ptr=1.
  task automatic test_hold();
    bus.hold = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus.gnt !== 4'b0000 || bus.ticket !== 9'h000 || bus.count !== 8'd1) begin
        fails++; $display("FAIL hold_%0d: got gnt=%b ticket=%0h count=%0d expected 0000/0/1",
                          i, bus.gnt, bus.ticket, bus.count);
      end
      next_cycle();
    end
    bus.hold = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.gnt !== 4'b0010 || bus.ticket !== 9'h101) begin
      fails++; $display("FAIL hold_resume: got gnt=%b ticket=%0h expected gnt=0010 ticket=101",
                        bus.gnt, bus.ticket);
    end
    $display("[TB] hold resume gnt=%b ticket=%0h", bus.gnt, bus.ticket);
    next_cycle();
    bus.req = 4'b0000;
  endtask

  // Scenario 5: clr at count=37, epoch=1.
  task automatic test_clear();
    bus.req = 4'b0001;
    for (int i = 0; i < 35; i++) next_cycle();
    bus.req = 4'b0000;
    @(negedge clk);
    tests++;
    if (bus.count !== 8'd37 || bus.epoch !== 1'b1) begin
      fails++; $display("FAIL clear_pre: got count=%0d epoch=%b expected 37/1", bus.count, bus.epoch);
    end
    next_cycle();
    bus.clr = 1'b1;
    bus.req = 4'b0010;
    @(negedge clk);
    tests++;
    if (bus.gnt !== 4'b0000 || bus.ticket !== 9'h000) begin
      fails++; $display("FAIL clear_cycle: got gnt=%b ticket=%0h expected 0000/0", bus.gnt, bus.ticket);
    end
    next_cycle();
    bus.clr = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.count !== 8'd0 || bus.epoch !== 1'b0 || bus.gnt !== 4'b0010 || bus.ticket !== 9'h000) begin
      fails++; $display("FAIL clear_after: got count=%0d epoch=%b gnt=%b ticket=%0h expected 0/0/0010/0",
                        bus.count, bus.epoch, bus.gnt, bus.ticket);
    end
    $display("[TB] after clear gnt=%b ticket=%0h", bus.gnt, bus.ticket);
    next_cycle();
  endtask

  // Scenario 6: async reset mid-burst at count=5, ptr=2.
  task automatic test_async_reset();
    bus.req = 4'b0010;
    for (int i = 0; i < 4; i++) next_cycle();
    bus.req = 4'b1111;
    @(negedge clk);
    tests++;
    if (bus.count !== 8'd5 || bus.gnt !== 4'b0100 || bus.ticket !== 9'h005) begin
      fails++; $display("FAIL burst_pre: got count=%0d gnt=%b ticket=%0h expected 5/0100/5",
                        bus.count, bus.gnt, bus.ticket);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.count !== 8'd0 || bus.epoch !== 1'b0 || bus.gnt !== 4'b0000 || bus.ticket !== 9'h000) begin
      fails++; $display("FAIL async_reset: got count=%0d epoch=%b gnt=%b ticket=%0h expected 0/0/0000/0",
                        bus.count, bus.epoch, bus.gnt, bus.ticket);
    end
    next_cycle();
    tests++;
    if (bus.count !== 8'd0) begin
      fails++; $display("FAIL reset_hold_count: got %0d expected 0", bus.count);
    end
    rst_n = 1'b1;
    bus.req = 4'b0110;
    @(negedge clk);
    tests++;
    if (bus.gnt !== 4'b0010 || bus.ticket !== 9'h000) begin
      fails++; $display("FAIL post_reset: got gnt=%b ticket=%0h expected 0010/0", bus.gnt, bus.ticket);
    end
    $display("[TB] post reset gnt=%b ticket=%0h", bus.gnt, bus.ticket);
    next_cycle();
    bus.req = 4'b0000;
    @(negedge clk);
    tests++;
    if (bus.count !== 8'd1) begin
      fails++; $display("FAIL post_reset_count: got %0d expected 1", bus.count);
    end
    next_cycle();
  endtask

  // Consumer ordering helper across an epoch boundary.
  task automatic test_ordering();
    ticket_t a, b;
    a = '{epoch: 1'b0, seq: 8'd5};   b = '{epoch: 1'b0, seq: 8'd6};
    tests++;
    if (ticket_older(a, b) !== 1'b1) begin
      fails++; $display("FAIL older_same_epoch: got %b expected 1", ticket_older(a, b));
    end
    a = '{epoch: 1'b1, seq: 8'd0};   b = '{epoch: 1'b0, seq: 8'd255};
    tests++;
    if (ticket_older(a, b) !== 1'b0) begin
      fails++; $display("FAIL older_new_epoch: got %b expected 0", ticket_older(a, b));
    end
    tests++;
    if (ticket_older(b, a) !== 1'b1) begin
      fails++; $display("FAIL older_old_epoch: got %b expected 1", ticket_older(b, a));
    end
    $display("[TB] ordering helper checked");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_rotation();
    test_sparse();
    test_wrap();
    test_hold();
    test_clear();
    test_async_reset();
    test_ordering();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
